mac_datapath: RTL and testbench
===============================

# mac_datapath

Arithmetic datapath of the MAC unit, driven directly by the MAC controller's load and enable strobes. It registers signed operand pairs and forms their product. It accumulates products into a wide accumulator, counts the terms loaded, and raises the terminal-count flag the controller uses to end a run. It also captures the final sum and term count into output registers for display.

## Interface
Parameters:
- DATA_W, 8: width of each signed operand.
- ACC_W, 24: accumulator and result width. Must satisfy ACC_W ≥ 2·DATA_W.
- N_TERMS, 8: maximum terms per run, ≥ 1.
- CNT_W, 4: term-counter width. Must satisfy 2^CNT_W > N_TERMS.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low. All registers clear.
- a_in, in, DATA_W: operand A, two's complement.
- b_in, in, DATA_W: operand B, two's complement.
- ld_a, in, 1: load a_in into reg_a.
- ld_b, in, 1: load b_in into reg_b.
- ld_acc, in, 1: acc ← acc + sext(reg_a·reg_b).
- count_en, in, 1: increment the term counter.
- ld_count, in, 1: capture the term counter into term_count.
- ld_out, in, 1: capture acc into mac_out.
- tc, out, 1: terminal count (combinational).
- mac_out, out, ACC_W: registered final sum, signed.
- term_count, out, CNT_W: registered number of terms loaded.
- ovf, out, 1: sticky signed-overflow flag.

## Operation
- **Reset:** reg_a, reg_b, acc, cnt, mac_out, term_count and ovf are all 0. tc is 0 because count_en is 0 while reset is asserted upstream.
- **Operand load:** reg_a and reg_b load independently on their strobes; otherwise they hold.
- **Product:** prod = signed(reg_a) × signed(reg_b), 2·DATA_W bits, combinational from the registers.
- **Accumulate:** on ld_acc, acc ← acc + sign-extended prod, modulo 2^ACC_W (wrap).
  - The product used is from the operands registered before the current edge. This forms a one-stage pipeline.
  - When ld_a, ld_b and ld_acc are asserted together, the edge adds the previous pair and loads the new pair.
  - The first such cycle after reset adds 0·0 = 0.
  - One trailing ld_acc-only cycle flushes the last pair.
- **Overflow:** ovf sets when both addends have the same sign and the sum's sign differs. It is sticky and cleared only by rst_n.
- **Term counter:** on count_en, cnt ← cnt + 1. It saturates at N_TERMS and never wraps.
- **Terminal count:** tc = count_en && (cnt == N_TERMS−1). It is asserted in the cycle the N_TERMS-th pair is loaded.
- **Count capture:** on ld_count, term_count ← cnt. When captured in the flush cycle, this equals the number of pairs loaded.
- **Result capture:** on ld_out, mac_out ← acc. It holds until the next ld_out or reset.
- **Precedence:** all strobes are independent, and simultaneous assertion of any combination is legal.
- **Restart:** a new run requires rst_n. There is no other clear of acc or cnt.

## Timing
- **Per-run sequence (controller order):**
  - k cycles of {ld_a, ld_b, ld_acc, count_en}.
  - 1 cycle of {ld_acc, ld_count}.
  - 1 cycle of {ld_out}.
- **Latency:** mac_out is valid on the edge ending the ld_out cycle, k+2 cycles after the first load cycle.
- **tc timing:** tc is combinational and must settle within the same cycle, because the controller samples it at the same edge.
- **Reset:** asynchronous rst_n assertion mid-run clears every register immediately, including ovf and mac_out. Deassertion must be synchronised at the top level.
- **Count saturation:** count_en held past saturation keeps cnt = N_TERMS, and tc stays 0.

## Structure
- **Shared package mac_pkg:**
  - Default values for DATA_W, ACC_W, N_TERMS and CNT_W.
  - The strobe-bundle typedef (ld_a, ld_b, ld_acc, count_en, ld_count, ld_out), shared with the controller.
- **Sub-module mac_term_counter:** the saturating counter plus tc decode. Parameters N_TERMS and CNT_W; ports clk, rst_n, count_en, cnt, tc.
- **Top level:** operand registers, multiplier, accumulator and overflow logic, output registers.

## Test plan
- **Full run:** ACC_W=24, N_TERMS=4. Load pairs (1,2), (3,4), (−5,6), (7,−8), then flush, then ld_out.
  - mac_out = −72 (0xFFFFB8), term_count = 4, ovf = 0.
  - tc is high only during the 4th load cycle.
- **Early stop:** N_TERMS=4. Load only (1,2) and (3,4), then flush and ld_out.
  - mac_out = 14, term_count = 2, tc never asserted.
- **Overflow:** DATA_W=8, ACC_W=16. Load two pairs of (−128,−128), then flush.
  - acc = 0x8000 (−32768), ovf = 1.
  - ovf stays 1 through ld_out and clears only on rst_n.
- **Reset mid-run:** assert rst_n low during the 3rd load cycle, asynchronous to clk.
  - All outputs read 0 before the next edge.
  - A subsequent full run matches the full-run scenario's results.
- **Count saturation:** N_TERMS=3. Hold count_en for 6 cycles.
  - cnt stops at 3, tc is high only when cnt = 2, and ld_count gives term_count = 3.
- **Pipeline first cycle:** after reset, assert {ld_a, ld_b, ld_acc} with (100,100).
  - acc stays 0 at that edge.
  - A following ld_acc-only cycle gives acc = 10000.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - Shared defaults and strobe bundle for the MAC datapath and controller.
package mac_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_N_TERMS = 8;
  localparam int DEF_CNT_W   = 4;

  // Field order matches the controller's strobe word.
  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic ld_acc;
    logic count_en;
    logic ld_count;
    logic ld_out;
  } mac_strobes_t;

endpackage

// File: rtl/mac_datapath_if.sv
// rtl/mac_datapath_if.sv - Controller-to-datapath operand, strobe and result bundle.
interface mac_datapath_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  mac_strobes_t      strb;
  logic              tc;
  logic [ACC_W-1:0]  mac_out;
  logic [CNT_W-1:0]  term_count;
  logic              ovf;

  modport master (
    output a_in, b_in, strb,
    input  tc, mac_out, term_count, ovf
  );

  modport slave (
    input  a_in, b_in, strb,
    output tc, mac_out, term_count, ovf
  );

endinterface

// File: rtl/mac_term_counter.sv
// rtl/mac_term_counter.sv - Saturating term counter with combinational terminal-count decode.
module mac_term_counter
  import mac_pkg::*;
#(
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (count_en && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Settles in the same cycle so the controller can stop on this edge.
  assign tc = count_en && (cnt == CNT_LAST);

endmodule

// File: rtl/mac_datapath.sv
// rtl/mac_datapath.sv - MAC datapath: operand registers, multiplier, wrapping accumulator, result capture.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_datapath_if.slave  bus
);

  logic signed [DATA_W-1:0]   reg_a;
  logic signed [DATA_W-1:0]   reg_b;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum;
  logic                       add_ovf;
  logic [CNT_W-1:0]           cnt;
  logic                       tc;
  logic [ACC_W-1:0]           mac_out_q;
  logic [CNT_W-1:0]           term_count_q;
  logic                       ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (bus.strb.ld_a) reg_a <= $signed(bus.a_in);
      if (bus.strb.ld_b) reg_b <= $signed(bus.b_in);
    end
  end

  // The accumulator sees the pair registered before this edge: a one-stage pipeline.
  assign prod     = reg_a * reg_b;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc + prod_ext;
  assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf_q <= 1'b0;
    end else if (bus.strb.ld_acc) begin
      acc <= sum;
      if (add_ovf) ovf_q <= 1'b1;
    end
  end

  mac_term_counter #(
    .N_TERMS (N_TERMS),
    .CNT_W   (CNT_W)
  ) u_term_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (bus.strb.count_en),
    .cnt      (cnt),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_out_q    <= '0;
      term_count_q <= '0;
    end else begin
      if (bus.strb.ld_out)   mac_out_q    <= acc;
      if (bus.strb.ld_count) term_count_q <= cnt;
    end
  end

  assign bus.tc         = tc;
  assign bus.mac_out    = mac_out_q;
  assign bus.term_count = term_count_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_mac_datapath.sv
// tb/tb_mac_datapath.sv - Scoreboard bench for mac_datapath across two parameter sets.
module tb_mac_datapath;
  import mac_pkg::*;

  localparam mac_strobes_t S_IDLE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam mac_strobes_t S_LOAD  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam mac_strobes_t S_FLUSH = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam mac_strobes_t S_OUT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam mac_strobes_t S_PIPE  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam mac_strobes_t S_ACC   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam mac_strobes_t S_CNT   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam mac_strobes_t S_LDCNT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic [23:0] sb_a[$];
  logic [15:0] sb_b[$];

  always #5 clk = ~clk;

  mac_datapath_if #(.DATA_W(8), .ACC_W(24), .CNT_W(4)) bus_a ();
  mac_datapath_if #(.DATA_W(8), .ACC_W(16), .CNT_W(4)) bus_b ();

  mac_datapath #(.DATA_W(8), .ACC_W(24), .N_TERMS(4), .CNT_W(4)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );

  mac_datapath #(.DATA_W(8), .ACC_W(16), .N_TERMS(3), .CNT_W(4)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  task automatic drive_a(input mac_strobes_t s, input int a, input int b, output logic tc_o);
    @(negedge clk);
    bus_a.strb = s;
    bus_a.a_in = a[7:0];
    bus_a.b_in = b[7:0];
    #1 tc_o = bus_a.tc;
  endtask

  task automatic drive_b(input mac_strobes_t s, input int a, input int b, output logic tc_o);
    @(negedge clk);
    bus_b.strb = s;
    bus_b.a_in = a[7:0];
    bus_b.b_in = b[7:0];
    #1 tc_o = bus_b.tc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_a.strb = S_IDLE;
    bus_b.strb = S_IDLE;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_a(input int n, input int av[4], input int bv[4], input string tag);
    int sum = 0;
    logic t;
    logic [23:0] exp_out;
    for (int i = 0; i < n; i++) begin
      drive_a(S_LOAD, av[i], bv[i], t);
      sum += av[i] * bv[i];
      checks++;
      if (t !== (i == 3)) $display("FAIL %s tc load%0d: got %b want %b", tag, i, t, (i == 3));
      else passes++;
    end
    drive_a(S_FLUSH, 0, 0, t);
    checks++;
    if (t !== 1'b0) $display("FAIL %s tc flush: got %b want 0", tag, t);
    else passes++;
    sb_a.push_back(sum[23:0]);
    drive_a(S_OUT, 0, 0, t);
    drive_a(S_IDLE, 0, 0, t);
    exp_out = sb_a.pop_front();
    checks++;
    if (bus_a.mac_out !== exp_out) $display("FAIL %s mac_out: got %h want %h", tag, bus_a.mac_out, exp_out);
    else passes++;
    checks++;
    if (bus_a.term_count !== 4'(n)) $display("FAIL %s term_count: got %0d want %0d", tag, bus_a.term_count, n);
    else passes++;
    checks++;
    if (bus_a.ovf !== 1'b0) $display("FAIL %s ovf: got %b want 0", tag, bus_a.ovf);
    else passes++;
  endtask

  task automatic test_reset();
    bus_a.strb = S_IDLE; bus_a.a_in = '0; bus_a.b_in = '0;
    bus_b.strb = S_IDLE; bus_b.a_in = '0; bus_b.b_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.mac_out, bus_a.term_count, bus_a.ovf, bus_a.tc} !== '0)
      $display("FAIL reset_a: got %h/%h/%b/%b want 0", bus_a.mac_out, bus_a.term_count, bus_a.ovf, bus_a.tc);
    else passes++;
    checks++;
    if ({bus_b.mac_out, bus_b.term_count, bus_b.ovf, bus_b.tc} !== '0)
      $display("FAIL reset_b: got %h/%h/%b/%b want 0", bus_b.mac_out, bus_b.term_count, bus_b.ovf, bus_b.tc);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_full_run();
    int av[4] = '{1, 3, -5, 7};
    int bv[4] = '{2, 4, 6, -8};
    run_a(4, av, bv, "full_run");
    checks++;
    if (bus_a.mac_out !== 24'hFFFFB8) $display("FAIL full_run literal: got %h want ffffb8", bus_a.mac_out);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    int av[4] = '{1, 3, -5, 7};
    int bv[4] = '{2, 4, 6, -8};
    logic t;
    drive_a(S_LOAD, 1, 2, t);
    drive_a(S_LOAD, 3, 4, t);
    drive_a(S_LOAD, -5, 6, t);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.mac_out !== '0) $display("FAIL midreset mac_out: got %h want 0", bus_a.mac_out);
    else passes++;
    checks++;
    if (bus_a.term_count !== '0) $display("FAIL midreset term_count: got %0d want 0", bus_a.term_count);
    else passes++;
    checks++;
    if ({bus_a.ovf, bus_a.tc} !== 2'b00) $display("FAIL midreset ovf/tc: got %b%b want 00", bus_a.ovf, bus_a.tc);
    else passes++;
    @(negedge clk);
    bus_a.strb = S_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    run_a(4, av, bv, "rerun");
  endtask

  task automatic test_early_stop();
    int av[4] = '{1, 3, 0, 0};
    int bv[4] = '{2, 4, 0, 0};
    do_reset();
    run_a(2, av, bv, "early_stop");
  endtask

  task automatic test_pipeline_first();
    logic t;
    do_reset();
    drive_a(S_PIPE, 100, 100, t);
    sb_a.push_back(24'd0);
    drive_a(S_OUT, 0, 0, t);
    drive_a(S_IDLE, 0, 0, t);
    begin
      logic [23:0] e = sb_a.pop_front();
      checks++;
      if (bus_a.mac_out !== e) $display("FAIL pipe_first: got %h want %h", bus_a.mac_out, e);
      else passes++;
    end
    drive_a(S_ACC, 0, 0, t);
    sb_a.push_back(24'd10000);
    drive_a(S_OUT, 0, 0, t);
    drive_a(S_IDLE, 0, 0, t);
    begin
      logic [23:0] e = sb_a.pop_front();
      checks++;
      if (bus_a.mac_out !== e) $display("FAIL pipe_flush: got %h want %h", bus_a.mac_out, e);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    logic t;
    do_reset();
    drive_b(S_LOAD, -128, -128, t);
    drive_b(S_LOAD, -128, -128, t);
    drive_b(S_FLUSH, 0, 0, t);
    sb_b.push_back(16'h8000);
    drive_b(S_OUT, 0, 0, t);
    drive_b(S_IDLE, 0, 0, t);
    begin
      logic [15:0] e = sb_b.pop_front();
      checks++;
      if (bus_b.mac_out !== e) $display("FAIL ovf mac_out: got %h want %h", bus_b.mac_out, e);
      else passes++;
    end
    checks++;
    if (bus_b.ovf !== 1'b1) $display("FAIL ovf flag: got %b want 1", bus_b.ovf);
    else passes++;
    checks++;
    if (bus_b.term_count !== 4'd2) $display("FAIL ovf term_count: got %0d want 2", bus_b.term_count);
    else passes++;
    repeat (3) drive_b(S_IDLE, 0, 0, t);
    checks++;
    if (bus_b.ovf !== 1'b1) $display("FAIL ovf sticky: got %b want 1", bus_b.ovf);
    else passes++;
    do_reset();
    checks++;
    if (bus_b.ovf !== 1'b0) $display("FAIL ovf clear: got %b want 0", bus_b.ovf);
    else passes++;
  endtask

  task automatic test_saturation();
    logic t;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_b(S_CNT, 0, 0, t);
      checks++;
      if (t !== (i == 2)) $display("FAIL sat tc cycle%0d: got %b want %b", i, t, (i == 2));
      else passes++;
    end
    drive_b(S_LDCNT, 0, 0, t);
    drive_b(S_IDLE, 0, 0, t);
    checks++;
    if (bus_b.term_count !== 4'd3) $display("FAIL sat term_count: got %0d want 3", bus_b.term_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_reset_mid_run();
    test_early_stop();
    test_pipeline_first();
    test_overflow();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
